// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control and status bundle for pwm_multi.
// The center signal exists only when PWM_CENTER_ALIGN_EN is defined.
interface pwm_multi_if #(
    parameter int R = 8,
    parameter int N = 4,
    parameter int P = 8
);
    logic           en;
    logic [P-1:0]   prescale;
    logic [R-1:0]   top;
    logic [N*R-1:0] duty;
    logic           load;
    logic [N-1:0]   pwm_out;
    logic           period_start;
    logic           load_ack;
`ifdef PWM_CENTER_ALIGN_EN
    logic           center;

    modport master (
        output en, prescale, top, duty, load, center,
        input  pwm_out, period_start, load_ack
    );
    modport slave (
        input  en, prescale, top, duty, load, center,
        output pwm_out, period_start, load_ack
    );
`else
    modport master (
        output en, prescale, top, duty, load,
        input  pwm_out, period_start, load_ack
    );
    modport slave (
        input  en, prescale, top, duty, load,
        output pwm_out, period_start, load_ack
    );
`endif
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM sharing one prescaled period counter with double-buffered top/duty.
// Define PWM_CENTER_ALIGN_EN to add up/down (center-aligned) counting selected by bus.center.
module pwm_multi #(
    parameter int R = 8,
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    pwm_multi_if.slave bus
);
    localparam logic [R-1:0] CNT_ZERO = {R{1'b0}};
    localparam logic [R-1:0] CNT_ONE  = {{(R-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] PRE_ZERO = {P{1'b0}};
    localparam logic [P-1:0] PRE_ONE  = {{(P-1){1'b0}}, 1'b1};

    logic [P-1:0]   pre_cnt_r;
    logic [R-1:0]   cnt_r;
    logic [R-1:0]   top_act_r;
    logic [R-1:0]   top_stg_r;
    logic [N*R-1:0] duty_act_r;
    logic [N*R-1:0] duty_stg_r;
    logic           pending_r;
    logic           load_ack_r;
    logic           period_start_r;
    logic           tick_s;
    logic           boundary_s;
    logic           commit_s;
    logic [R-1:0]   cnt_nxt_s;
    logic [N-1:0]   pwm_s;
`ifdef PWM_CENTER_ALIGN_EN
    logic           center_act_r;
    logic           dir_down_r;
    logic           dir_nxt_s;
`endif

    // Prescaler tick and commit qualification (a disabled block commits immediately)
    always_comb begin
        tick_s   = bus.en && (pre_cnt_r == bus.prescale);
        commit_s = pending_r && (boundary_s || !bus.en);
    end

    // Next counter value and period boundary detection
    always_comb begin
        boundary_s = 1'b0;
        cnt_nxt_s  = cnt_r;
`ifdef PWM_CENTER_ALIGN_EN
        dir_nxt_s  = dir_down_r;
`endif
        if (!tick_s) begin
            cnt_nxt_s = cnt_r;
        end else if (top_act_r == CNT_ZERO) begin
            boundary_s = 1'b1;
            cnt_nxt_s  = CNT_ZERO;
`ifdef PWM_CENTER_ALIGN_EN
            dir_nxt_s  = 1'b0;
        end else if (center_act_r && (dir_down_r || (cnt_r == top_act_r))) begin
            // Falling half: the step from 1 onto 0 closes the period
            cnt_nxt_s  = cnt_r - CNT_ONE;
            boundary_s = (cnt_r == CNT_ONE);
            dir_nxt_s  = (cnt_r != CNT_ONE);
`endif
        end else if (cnt_r == top_act_r) begin
            boundary_s = 1'b1;
            cnt_nxt_s  = CNT_ZERO;
        end else begin
            cnt_nxt_s  = cnt_r + CNT_ONE;
        end
    end

    // Prescaler and period counter, both held at zero while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r  <= PRE_ZERO;
            cnt_r      <= CNT_ZERO;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r <= 1'b0;
`endif
        end else if (!bus.en) begin
            pre_cnt_r  <= PRE_ZERO;
            cnt_r      <= CNT_ZERO;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r <= 1'b0;
`endif
        end else begin
            pre_cnt_r  <= tick_s ? PRE_ZERO : (pre_cnt_r + PRE_ONE);
            cnt_r      <= cnt_nxt_s;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_r <= dir_nxt_s;
`endif
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Counting mode may only change where the counter restarts from 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            center_act_r <= 1'b0;
        end else if (boundary_s || !bus.en) begin
            center_act_r <= bus.center;
        end else begin
            center_act_r <= center_act_r;
        end
    end
`endif

    // Double-buffered top/duty: stage on load, activate on commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_stg_r  <= CNT_ZERO;
            duty_stg_r <= {(N*R){1'b0}};
            top_act_r  <= {R{1'b1}};
            duty_act_r <= {(N*R){1'b0}};
            pending_r  <= 1'b0;
        end else begin
            if (bus.load) begin
                top_stg_r  <= bus.top;
                duty_stg_r <= bus.duty;
            end
            if (commit_s) begin
                top_act_r  <= top_stg_r;
                duty_act_r <= duty_stg_r;
            end
            pending_r <= bus.load || (pending_r && !commit_s);
        end
    end

    // Single-cycle status pulses, one clock after the triggering edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_ack_r     <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            load_ack_r     <= commit_s;
            period_start_r <= boundary_s;
        end
    end

    // Channel compare straight from registers: no added latency, no glitch source
    always_comb begin
        pwm_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            pwm_s[i] = bus.en && (cnt_r < duty_act_r[i*R +: R]);
        end
    end

    assign bus.pwm_out      = pwm_s;
    assign bus.period_start = period_start_r;
    assign bus.load_ack     = load_ack_r;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scenarios plus randomized traffic checked every cycle against a
// position-in-period reference model of pwm_multi.
`timescale 1ns/1ps
module tb_pwm_multi;
    localparam int R = 8;
    localparam int N = 4;
    localparam int P = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pwm_multi_if #(.R(R), .N(N), .P(P)) bus ();
    pwm_multi #(.R(R), .N(N), .P(P)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within the period rather than a counter register
    int m_pre, m_pos, m_top, m_stg_top, m_pend, m_ack, m_ps, m_center, m_len;
    int m_duty [N];
    int m_stg_duty [N];
    bit m_tick, m_bnd, m_commit;
    int c_hi [N];
    int c_ps, c_ack;
    logic [N-1:0] exp_pwm;

    function automatic int m_cnt();
        return (m_pos <= m_top) ? m_pos : (2 * m_top - m_pos);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pre = 0; m_pos = 0; m_top = (1 << R) - 1; m_stg_top = 0;
            m_pend = 0; m_ack = 0; m_ps = 0; m_center = 0;
            for (int i = 0; i < N; i++) begin
                m_duty[i] = 0;
                m_stg_duty[i] = 0;
            end
        end else begin
            m_tick   = bus.en && (m_pre == int'(bus.prescale));
            m_len    = (m_center != 0 && m_top > 0) ? 2 * m_top : m_top + 1;
            m_bnd    = m_tick && (m_pos == m_len - 1);
            m_commit = (m_pend != 0) && (m_bnd || !bus.en);
            if (!bus.en) begin
                m_pre = 0;
                m_pos = 0;
            end else begin
                m_pre = m_tick ? 0 : (m_pre + 1) % (1 << P);
                if (m_tick) m_pos = m_bnd ? 0 : m_pos + 1;
            end
`ifdef PWM_CENTER_ALIGN_EN
            if (m_bnd || !bus.en) m_center = int'(bus.center);
`endif
            m_ps  = int'(m_bnd);
            m_ack = int'(m_commit);
            if (m_commit) begin
                m_top = m_stg_top;
                for (int i = 0; i < N; i++) m_duty[i] = m_stg_duty[i];
            end
            if (bus.load) begin
                m_stg_top = int'(bus.top);
                for (int i = 0; i < N; i++) m_stg_duty[i] = int'(bus.duty[i*R +: R]);
                m_pend = 1;
            end else if (m_commit) begin
                m_pend = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) exp_pwm[i] = bus.en && (m_cnt() < m_duty[i]);
        check("pwm_out", int'(bus.pwm_out), int'(exp_pwm));
        check("period_start", int'(bus.period_start), m_ps);
        check("load_ack", int'(bus.load_ack), m_ack);
    end

    task automatic run_count(input int n);
        for (int i = 0; i < N; i++) c_hi[i] = 0;
        c_ps = 0;
        c_ack = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) c_hi[i] += int'(bus.pwm_out[i]);
            c_ps  += int'(bus.period_start);
            c_ack += int'(bus.load_ack);
        end
    endtask

    task automatic do_load(input logic [R-1:0] t, input logic [N*R-1:0] d);
        @(posedge clk);
        #1;
        bus.top  = t;
        bus.duty = d;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait expired, got none, expected event", name);
    endtask

    initial begin
        bit found;
        bus.en = 1'b0; bus.prescale = 8'd0; bus.top = 8'd0; bus.duty = 32'd0; bus.load = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        bus.center = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_ps", int'(bus.period_start), 0);
        check("rst_ack", int'(bus.load_ack), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Load while disabled commits on the following clock
        do_load(8'd9, {8'd255, 8'd10, 8'd3, 8'd0});
        run_count(1);
        check("dis_ack_early", c_ack, 0);
        run_count(1);
        check("dis_ack", c_ack, 1);
        check("dis_pwm_low", c_hi[0] + c_hi[1] + c_hi[2] + c_hi[3], 0);

        // top=9, prescale=0: 10-clock period, three periods observed
        @(posedge clk);
        #1 bus.en = 1'b1;
        run_count(30);
        check("p10_ch0", c_hi[0], 0);
        check("p10_ch1", c_hi[1], 9);
        check("p10_ch2", c_hi[2], 30);
        check("p10_ch3", c_hi[3], 30);
        check("p10_ps", c_ps, 2);

        // Reload duty1 mid-period: old value holds until the wrap
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            #1;
            if (m_pos == 5) found = 1'b1;
        end
        if (!found) timeout_fail("mid_sync");
        #1;
        bus.duty = {8'd255, 8'd10, 8'd7, 8'd0};
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        run_count(4);
        check("mid_ch1_old", c_hi[1], 0);
        check("mid_ack_early", c_ack, 0);
        run_count(10);
        check("mid_ch1_new", c_hi[1], 7);
        check("mid_ack", c_ack, 1);
        check("mid_ps", c_ps, 1);

        // prescale=2, top=4: 15-clock period, ch1 high 6 clocks
        @(posedge clk);
        #1;
        bus.prescale = 8'd2;
        bus.top  = 8'd4;
        bus.duty = {8'd255, 8'd10, 8'd2, 8'd0};
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            #1;
            if (m_ack != 0) found = 1'b1;
        end
        if (!found) timeout_fail("pre_ack");
        run_count(15);
        check("pre_ch0", c_hi[0], 0);
        check("pre_ch1", c_hi[1], 6);
        check("pre_ch2", c_hi[2], 15);
        check("pre_ps", c_ps, 1);

        // Asynchronous reset while ch1 is high
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            #1;
            if (m_cnt() == 1) found = 1'b1;
        end
        if (!found) timeout_fail("rst_sync");
        check("pre_rst_ch1", int'(bus.pwm_out[1]), 1);
        #1 reset_n = 1'b0;
        #1 check("async_rst_pwm", int'(bus.pwm_out), 0);
        bus.prescale = 8'd0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        run_count(300);
        check("post_rst_duty", c_hi[0] + c_hi[1] + c_hi[2] + c_hi[3], 0);
        check("post_rst_top255", c_ps, 1);

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: top=4 gives an 8-clock period, ch1 high 3 of 8
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        bus.center = 1'b1;
        do_load(8'd4, {8'd0, 8'd0, 8'd2, 8'd0});
        run_count(2);
        @(posedge clk);
        #1 bus.en = 1'b1;
        run_count(16);
        check("ctr_ch1", c_hi[1], 6);
        check("ctr_ps", c_ps, 1);
`endif

        // Randomized traffic; the every-cycle compare does the checking
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            bus.en   = ($urandom_range(0, 15) != 0);
            bus.load = ($urandom_range(0, 24) == 0);
            if (bus.load) begin
                bus.top = R'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 2 : 12));
                for (int i = 0; i < N; i++) bus.duty[i*R +: R] = R'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 63) == 0) bus.prescale = P'($urandom_range(0, 3));
`ifdef PWM_CENTER_ALIGN_EN
            if ($urandom_range(0, 31) == 0) bus.center = ~bus.center;
`endif
        end
        bus.load = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
